// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive sequencing controller.
package uart_pkg;

  typedef enum logic [1:0] {
    StInit,
    StIdle,
    StRun,
    StFlush
  } rx_state_e;

  localparam int unsigned FLUSH_CYCLES   = 2;
  localparam int unsigned RX_FRAME_EDGES = 12;
  localparam int unsigned ENTRY_WIDTH    = 9;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous byte FIFO with registered head outputs and a drop pulse on push-when-full.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [ENTRY_WIDTH-1:0] wdata_i,
  input  logic                   ready_i,
  output logic                   valid_o,
  output logic [ENTRY_WIDTH-1:0] rdata_o,
  output logic                   drop_o
);

  localparam int unsigned Aw = $clog2(Depth);

  logic [ENTRY_WIDTH-1:0] mem_q [Depth];
  logic [Aw:0]            wptr_q, wptr_d, rptr_q, rptr_d;
  logic                   valid_q, valid_d;
  logic [ENTRY_WIDTH-1:0] head_q, head_d;
  logic                   full, pop, do_push;

  assign full    = (wptr_q[Aw] != rptr_q[Aw]) && (wptr_q[Aw-1:0] == rptr_q[Aw-1:0]);
  assign pop     = valid_q & ready_i;
  assign do_push = push_i & (~full | pop);
  assign drop_o  = push_i & full & ~pop;

  always_comb begin
    rptr_d  = rptr_q + {{Aw{1'b0}}, pop};
    wptr_d  = wptr_q + {{Aw{1'b0}}, do_push};
    valid_d = (wptr_d != rptr_d);
    head_d  = head_q;
    if (valid_d) begin
      // The byte being written becomes the head when it lands on the new read slot.
      if (do_push && (rptr_d[Aw-1:0] == wptr_q[Aw-1:0])) begin
        head_d = wdata_i;
      end else begin
        head_d = mem_q[rptr_d[Aw-1:0]];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wptr_q[Aw-1:0]] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      valid_q <= 1'b0;
      head_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      valid_q <= valid_d;
      head_q  <= head_d;
    end
  end

  assign valid_o = valid_q;
  assign rdata_o = head_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver sequencer: baud generation, receiver clear, byte FIFO and error flags.
// Optional statistics counters are enabled by defining UART_RX_CTRL_STATS_EN.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV       = 5208,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned TIMEOUT_EDGES = 12
) (
  input  logic        CLK,
  input  logic        CLR_N,
  input  logic        en,
  input  logic        rx_line,
  output logic        rx_baud_clk,
  output logic        rx_clr,
  input  logic        rx_data_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_parity_err,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [7:0]  m_data,
  output logic        m_perr,
  output logic        overrun,
  output logic        frame_err,
  input  logic        err_clr
`ifdef UART_RX_CTRL_STATS_EN
  ,
  output logic [15:0] frame_cnt,
  output logic [15:0] perr_cnt
`endif
);

  localparam int unsigned PhW      = $clog2(CLK_DIV);
  localparam int unsigned Half     = CLK_DIV / 2;
  localparam int unsigned MaxEdges = (TIMEOUT_EDGES > RX_FRAME_EDGES) ? TIMEOUT_EDGES
                                                                      : RX_FRAME_EDGES;
  localparam int unsigned EdgeW    = $clog2(MaxEdges + 1);
  localparam int unsigned FlushW   = $clog2(FLUSH_CYCLES);

  rx_state_e            state_q, state_d;
  logic [FlushW-1:0]    flush_q, flush_d;
  logic [PhW-1:0]       phase_q, phase_d;
  logic [EdgeW-1:0]     edge_q, edge_d;
  logic                 seen_q, seen_d;
  logic                 baud_q, baud_d;
  logic                 sync1_q, sync2_q, hist_q;
  logic                 dr_hist_q;
  logic                 overrun_q, frame_err_q;
  logic                 fall, dr_rise, frame_set, drop;
  logic [ENTRY_WIDTH-1:0] head;

  assign fall    = hist_q & ~sync2_q;
  assign dr_rise = rx_data_ready & ~dr_hist_q;

  always_comb begin
    state_d   = state_q;
    flush_d   = flush_q;
    phase_d   = phase_q;
    edge_d    = edge_q;
    seen_d    = seen_q;
    frame_set = 1'b0;
    unique case (state_q)
      StInit, StFlush: begin
        if (flush_q == FlushW'(FLUSH_CYCLES - 1)) begin
          state_d = StIdle;
          flush_d = '0;
        end else begin
          flush_d = flush_q + 1'b1;
        end
      end
      StIdle: begin
        if (en && fall) begin
          state_d = StRun;
          phase_d = '0;
          edge_d  = '0;
          seen_d  = 1'b0;
        end
      end
      StRun: begin
        phase_d = (phase_q == PhW'(CLK_DIV - 1)) ? '0 : phase_q + 1'b1;
        if ((phase_q == PhW'(Half - 1)) && (edge_q != EdgeW'(MaxEdges))) begin
          edge_d = edge_q + 1'b1;
        end
        if (dr_rise) begin
          seen_d = 1'b1;
        end
        if (!seen_q && (edge_q >= EdgeW'(TIMEOUT_EDGES))) begin
          frame_set = 1'b1;
          state_d   = StFlush;
        end else if (seen_q && (edge_q >= EdgeW'(RX_FRAME_EDGES)) &&
                     (phase_q == PhW'(CLK_DIV - 1))) begin
          state_d = StIdle;
        end
      end
      default: state_d = StInit;
    endcase
    // Baud is high for the upper half of each bit period, so its rise lands mid-bit.
    baud_d = (state_d == StRun) && (phase_d >= PhW'(Half));
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state_q     <= StInit;
      flush_q     <= '0;
      phase_q     <= '0;
      edge_q      <= '0;
      seen_q      <= 1'b0;
      baud_q      <= 1'b0;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      hist_q      <= 1'b1;
      dr_hist_q   <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_q     <= flush_d;
      phase_q     <= phase_d;
      edge_q      <= edge_d;
      seen_q      <= seen_d;
      baud_q      <= baud_d;
      sync1_q     <= rx_line;
      sync2_q     <= sync1_q;
      hist_q      <= sync2_q;
      dr_hist_q   <= rx_data_ready;
      overrun_q   <= err_clr ? 1'b0 : (overrun_q | drop);
      frame_err_q <= err_clr ? 1'b0 : (frame_err_q | frame_set);
    end
  end

  uart_rx_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (CLR_N),
    .push_i  (dr_rise),
    .wdata_i ({rx_parity_err, rx_data}),
    .ready_i (m_ready),
    .valid_o (m_valid),
    .rdata_o (head),
    .drop_o  (drop)
  );

  assign rx_baud_clk = baud_q;
  assign rx_clr      = (state_q == StInit) || (state_q == StFlush);
  assign m_data      = head[7:0];
  assign m_perr      = head[8];
  assign overrun     = overrun_q;
  assign frame_err   = frame_err_q;

`ifdef UART_RX_CTRL_STATS_EN
  logic [15:0] frame_cnt_q, perr_cnt_q;

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      frame_cnt_q <= '0;
      perr_cnt_q  <= '0;
    end else if (err_clr) begin
      frame_cnt_q <= '0;
      perr_cnt_q  <= '0;
    end else begin
      if (dr_rise && (frame_cnt_q != 16'hFFFF)) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
      if (dr_rise && rx_parity_err && (perr_cnt_q != 16'hFFFF)) begin
        perr_cnt_q <= perr_cnt_q + 16'd1;
      end
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign perr_cnt  = perr_cnt_q;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with a behavioural receiver attached to baud/clear.
module tb_uart_rx_ctrl;

  logic       CLK = 1'b0;
  logic       CLR_N = 1'b0;
  logic       en = 1'b1;
  logic       rx_line = 1'b1;
  logic       rx_baud_clk, rx_clr;
  logic       rx_data_ready;
  logic [7:0] rx_data;
  logic       rx_parity_err;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [7:0] m_data;
  logic       m_perr, overrun, frame_err;
  logic       err_clr = 1'b0;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Receiver model
  int         rcnt;
  logic [7:0] sh;
  logic       pe, rdy, bh;
  bit         kill = 1'b0;

  always #5 CLK = ~CLK;

  uart_rx_ctrl #(
    .CLK_DIV       (16),
    .FIFO_DEPTH    (4),
    .TIMEOUT_EDGES (12)
  ) dut (
    .CLK           (CLK),
    .CLR_N         (CLR_N),
    .en            (en),
    .rx_line       (rx_line),
    .rx_baud_clk   (rx_baud_clk),
    .rx_clr        (rx_clr),
    .rx_data_ready (rx_data_ready),
    .rx_data       (rx_data),
    .rx_parity_err (rx_parity_err),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .m_perr        (m_perr),
    .overrun       (overrun),
    .frame_err     (frame_err),
    .err_clr       (err_clr)
  );

  // Edge 1 start, edges 2-9 data LSB first, edge 10 parity, ready at 11, dropped at 12.
  always @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      rcnt <= 0; sh <= '0; pe <= 1'b0; rdy <= 1'b0; bh <= 1'b0;
    end else begin
      bh <= rx_baud_clk;
      if (rx_clr) begin
        rcnt <= 0;
        rdy  <= 1'b0;
      end else if (rx_baud_clk && !bh) begin
        if (rcnt >= 1 && rcnt <= 8) sh[rcnt-1] <= rx_line;
        if (rcnt == 9) pe <= (^sh) ^ rx_line;
        if (rcnt == 10) rdy <= !kill;
        if (rcnt == 11) begin
          rdy  <= 1'b0;
          rcnt <= 0;
        end else begin
          rcnt <= rcnt + 1;
        end
      end
    end
  end

  assign rx_data_ready = rdy;
  assign rx_data       = sh;
  assign rx_parity_err = pe;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic pop_one();
    m_ready = 1'b1;
    tick(1);
    m_ready = 1'b0;
  endtask

  // Drives one 11-bit frame plus idle tail; counts baud rises; optionally resets at an edge.
  task automatic send_frame(input logic [7:0] d, input bit flip, input bit chk,
                            input int abort_at, output int rises);
    logic [10:0] bits;
    logic        prev;
    bits  = {1'b1, (^d) ^ flip, d, 1'b0};
    rises = 0;
    prev  = rx_baud_clk;
    for (int c = 0; c < 206; c++) begin
      rx_line = (c < 176) ? bits[c/16] : 1'b1;
      @(posedge CLK);
      #1;
      if (rx_baud_clk && !prev) rises++;
      prev = rx_baud_clk;
      if (chk && c == 9)  check("baud_low_before_mid_start", rx_baud_clk, 1'b0);
      if (chk && c == 10) check("baud_first_rise", rx_baud_clk, 1'b1);
      if (abort_at != 0 && rises == abort_at) begin
        CLR_N = 1'b0;
        #1;
        check("rst_rx_clr", rx_clr, 1'b1);
        check("rst_baud", rx_baud_clk, 1'b0);
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_m_data", m_data, 8'h00);
        check("rst_m_perr", m_perr, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        rx_line = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    int         rises;
    int         seen_at;
    int         clr_cycles;
    bit         got_err;
    logic [7:0] exp_q [4];

    // Reset state
    tick(3);
    check("reset_rx_clr", rx_clr, 1'b1);
    check("reset_baud", rx_baud_clk, 1'b0);
    check("reset_m_valid", m_valid, 1'b0);
    check("reset_overrun", overrun, 1'b0);
    check("reset_frame_err", frame_err, 1'b0);
    CLR_N = 1'b1;
    tick(1);
    check("init_clr_cycle1", rx_clr, 1'b1);
    tick(1);
    check("init_clr_released", rx_clr, 1'b0);
    tick(4);

    // Good frame 0xA5
    send_frame(8'hA5, 1'b0, 1'b1, 0, rises);
    check("a5_edges", rises[15:0], 16'd12);
    check("a5_valid", m_valid, 1'b1);
    check("a5_data", m_data, 8'hA5);
    check("a5_perr", m_perr, 1'b0);
    check("a5_idle_baud", rx_baud_clk, 1'b0);
    pop_one();
    check("a5_popped", m_valid, 1'b0);

    // Parity error frame 0x3C
    send_frame(8'h3C, 1'b1, 1'b0, 0, rises);
    check("3c_valid", m_valid, 1'b1);
    check("3c_data", m_data, 8'h3C);
    check("3c_perr", m_perr, 1'b1);
    pop_one();

    // Overrun: five frames into a four-entry FIFO
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) send_frame(exp_q[i], 1'b0, 1'b0, 0, rises);
    check("fill_no_overrun", overrun, 1'b0);
    send_frame(8'h55, 1'b0, 1'b0, 0, rises);
    check("overrun_set", overrun, 1'b1);
    check("overrun_head_kept", m_data, 8'h11);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("overrun_cleared", overrun, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_%0d_valid", i), m_valid, 1'b1);
      check($sformatf("drain_%0d_data", i), m_data, exp_q[i]);
      pop_one();
    end
    check("drained_empty", m_valid, 1'b0);

    // Timeout: line held low, receiver never raises data-ready
    kill    = 1'b1;
    rx_line = 1'b0;
    rises   = 0;
    seen_at = -1;
    got_err = 1'b0;
    clr_cycles = 0;
    begin
      logic prev;
      prev = rx_baud_clk;
      for (int c = 0; c < 300; c++) begin
        tick(1);
        if (rx_baud_clk && !prev) rises++;
        prev = rx_baud_clk;
        if (got_err && rx_clr) clr_cycles++;
        if (!got_err && frame_err) begin
          got_err = 1'b1;
          seen_at = rises;
          if (rx_clr) clr_cycles++;
        end
      end
    end
    check("timeout_frame_err", {15'd0, got_err}, 16'd1);
    check("timeout_at_edge", seen_at[15:0], 16'd12);
    check("timeout_clr_cycles", clr_cycles[15:0], 16'd2);
    check("timeout_no_push", m_valid, 1'b0);
    rx_line = 1'b1;
    kill    = 1'b0;
    tick(10);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("frame_err_cleared", frame_err, 1'b0);

    // Reset mid-frame with a byte queued, then a clean frame
    send_frame(8'h77, 1'b0, 1'b0, 0, rises);
    check("pre_reset_valid", m_valid, 1'b1);
    send_frame(8'h99, 1'b0, 1'b0, 6, rises);
    tick(3);
    CLR_N = 1'b1;
    tick(6);
    send_frame(8'h55, 1'b0, 1'b0, 0, rises);
    check("post_reset_valid", m_valid, 1'b1);
    check("post_reset_data", m_data, 8'h55);
    check("post_reset_perr", m_perr, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
